pcx_req_loader: RTL
===================

// Module: pcx_req_loader
// PURPOSE
//  Upstream feeder of pcx_fifo: terminates the SPARC core PCX request port (req/atom/data), returns grants,
//  packs each packet into a 130-bit word {atom,req[4:0],data[123:0]} and drives pcx_fifo wrreq/data.
//  Tracks FIFO occupancy with its own credit counter so the core is never granted into a full FIFO.
//  Atomic (CAS) pairs always enter the FIFO back-to-back and complete, with two slots reserved up front.
// PARAMETERS
//  FIFO_DEPTH   32   entries in downstream pcx_fifo; credit counter ceiling
//  DATA_WIDTH   124  PCX packet payload width
//  REQ_WIDTH    5    one-hot PCX destination request width
// PORTS
//  clock               in   1    system clock, all state on rising edge
//  aclr_n              in   1    asynchronous active-low reset
//  spc_pcx_req_pq      in   5    request, level-held by core until granted; nonzero = request
//  spc_pcx_atom_pq     in   1    with req: first packet of an atomic pair
//  spc_pcx_data_pa     in   124  packet payload, valid in the cycle grant is high
//  pcx_spc_grant_px    out  5    registered one-cycle grant, echoes the accepted req bits
//  fifo_wrreq          out  1    registered write strobe to pcx_fifo
//  fifo_data           out  130  {atom, req[4:0], payload}, valid with fifo_wrreq
//  fifo_rdreq          in   1    copy of pcx_fifo rdreq (consumer pop), frees one credit
//  fifo_full           in   1    pcx_fifo full flag, used only for the error check
//  credits_used        out  6    reserved + stored entries (0..FIFO_DEPTH)
//  err                 out  1    sticky: overflow (wrreq while fifo_full) or underflow (rdreq at used==0)
// BEHAVIOUR
//  Reset: grant=0, fifo_wrreq=0, fifo_data=0, credits_used=0, err=0, FSM=IDLE. Reset mid-packet drops it.
//  FSM IDLE: req!=0 and atom=0 and used<=DEPTH-1 -> accept (used+=1) -> GNT.
//            req!=0 and atom=1 and used<=DEPTH-2 -> accept (used+=2) -> GNT_A1.
//            Insufficient credit -> stay IDLE, no grant; core holds req.
//  GNT / GNT_A1: grant=latched req for exactly this cycle; sample data_pa. Latch {atom,req,data} and
//   assert fifo_wrreq next cycle. Ignore req this cycle (it is the already-accepted request).
//   GNT -> IDLE; GNT_A1 -> ATOM_WAIT.
//  ATOM_WAIT: wait for next req!=0 (the second CAS packet); accept with no credit check or increment
//   (pre-reserved) -> GNT_A2. The atom bit on this req is ignored and stored as 0.
//  GNT_A2: as GNT, -> IDLE.
//  Timing: accept at N, grant+data at N+1, fifo_wrreq at N+2. Throughput: 1 packet per 2 cycles.
//  Credits: used' = used + inc(accept) - (fifo_rdreq && used!=0). Simultaneous accept and pop net out.
//   Credit check uses the pre-update used; a pop in the same cycle does not enable acceptance.
//  Errors: fifo_rdreq with used==0 -> no decrement, set err. fifo_wrreq while fifo_full -> set err.
//   err is cleared only by reset.
//  Widths: used is 6 bits (holds 32), never wraps; the saturating checks above guarantee 0..DEPTH.
// STRUCTURE
//  s1_pcx_pkg: PCX_DATA_WIDTH=124, PCX_REQ_WIDTH=5, PCX_FIFO_WIDTH=130, packed pcx_pkt_t {atom,req,data},
//   and the loader_state_t enum {IDLE,GNT,GNT_A1,ATOM_WAIT,GNT_A2}. pcx_fifo is to use the same width constant.
//  One sub-module: pcx_credit_ctr (inc 0/1/2, dec, underflow flag, count output).
// TESTING
//  1 Single store: req=5'b00001, atom=0, data=X at N+1 -> grant=00001 at N+1, wrreq with {0,00001,X} at N+2, used=1.
//  2 Fill: 32 packets, no pops -> 32 grants; 33rd req held, no grant while used=32; one pop -> grant 2 cycles later.
//  3 CAS at used=31: atom req withheld; pop -> used=30 -> accept; two FIFO writes back-to-back, atom bits 1 then 0, used=32.
//  4 Pop and accept same cycle at used=10 -> used stays 10. Pop at used=0 -> err=1, used stays 0.
//  5 aclr_n low during ATOM_WAIT -> all outputs 0 immediately; after release, a plain req is accepted normally.
//  6 Force fifo_full=1 while a write issues -> err=1 sticky until reset.

Source files
------------

// File: rtl/s1_pcx_pkg.sv
// Shared PCX request-path types and widths for the loader and pcx_fifo.
package s1_pcx_pkg;

    localparam int PCX_DATA_WIDTH  = 124;
    localparam int PCX_REQ_WIDTH   = 5;
    localparam int PCX_FIFO_WIDTH  = 130;
    localparam int PCX_CREDIT_WIDTH = 6;

    typedef struct packed {
        logic                     atom;
        logic [PCX_REQ_WIDTH-1:0] req;
        logic [PCX_DATA_WIDTH-1:0] data;
    } pcx_pkt_t;

    typedef enum logic [2:0] {
        IDLE,
        GNT,
        GNT_A1,
        ATOM_WAIT,
        GNT_A2
    } loader_state_t;

endpackage

// File: rtl/pcx_credit_ctr.sv
// Occupancy counter for the downstream FIFO: reservations in, consumer pops out.
module pcx_credit_ctr #(
    parameter int CNT_WIDTH = 6
) (
    input  logic                 clock,
    input  logic                 aclr_n,
    input  logic [1:0]           inc,
    input  logic                 dec,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 underflow
);

    logic pop_ok;

    // A pop with nothing outstanding is flagged but never decrements.
    assign underflow = dec && (count == '0);
    assign pop_ok    = dec && (count != '0);

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            count <= '0;
        end else begin
            count <= count + CNT_WIDTH'(inc) - CNT_WIDTH'(pop_ok);
        end
    end

endmodule

// File: rtl/pcx_req_loader.sv
// Terminates the core PCX request port, grants against FIFO credit and
// pushes packed {atom, req, data} words into pcx_fifo.
module pcx_req_loader
    import s1_pcx_pkg::*;
#(
    parameter int FIFO_DEPTH = 32,
    parameter int DATA_WIDTH = PCX_DATA_WIDTH,
    parameter int REQ_WIDTH  = PCX_REQ_WIDTH
) (
    input  logic                          clock,
    input  logic                          aclr_n,
    input  logic [REQ_WIDTH-1:0]          spc_pcx_req_pq,
    input  logic                          spc_pcx_atom_pq,
    input  logic [DATA_WIDTH-1:0]         spc_pcx_data_pa,
    output logic [REQ_WIDTH-1:0]          pcx_spc_grant_px,
    output logic                          fifo_wrreq,
    output logic [DATA_WIDTH+REQ_WIDTH:0] fifo_data,
    input  logic                          fifo_rdreq,
    input  logic                          fifo_full,
    output logic [PCX_CREDIT_WIDTH-1:0]   credits_used,
    output logic                          err
);

    localparam logic [PCX_CREDIT_WIDTH-1:0] LIM_ONE = PCX_CREDIT_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [PCX_CREDIT_WIDTH-1:0] LIM_TWO = PCX_CREDIT_WIDTH'(FIFO_DEPTH - 2);

    loader_state_t state, state_nxt;
    logic          accept;
    logic [1:0]    credit_inc;
    logic          atom_nxt;
    logic          atom_q;
    logic          wr_cycle;
    logic          underflow;

    pcx_credit_ctr #(
        .CNT_WIDTH (PCX_CREDIT_WIDTH)
    ) u_credit (
        .clock     (clock),
        .aclr_n    (aclr_n),
        .inc       (credit_inc),
        .dec       (fifo_rdreq),
        .count     (credits_used),
        .underflow (underflow)
    );

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        credit_inc = 2'd0;
        atom_nxt   = 1'b0;
        wr_cycle   = 1'b0;
        case (state)
            IDLE: begin
                if (spc_pcx_req_pq != '0) begin
                    if (!spc_pcx_atom_pq && credits_used <= LIM_ONE) begin
                        accept     = 1'b1;
                        credit_inc = 2'd1;
                        state_nxt  = GNT;
                    end else if (spc_pcx_atom_pq && credits_used <= LIM_TWO) begin
                        accept     = 1'b1;
                        credit_inc = 2'd2;
                        atom_nxt   = 1'b1;
                        state_nxt  = GNT_A1;
                    end
                end
            end
            GNT: begin
                wr_cycle  = 1'b1;
                state_nxt = IDLE;
            end
            GNT_A1: begin
                wr_cycle  = 1'b1;
                state_nxt = ATOM_WAIT;
            end
            // Second CAS half rides on the slot reserved by the first.
            ATOM_WAIT: begin
                if (spc_pcx_req_pq != '0) begin
                    accept    = 1'b1;
                    state_nxt = GNT_A2;
                end
            end
            GNT_A2: begin
                wr_cycle  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state            <= IDLE;
            pcx_spc_grant_px <= '0;
            atom_q           <= 1'b0;
            fifo_wrreq       <= 1'b0;
            fifo_data        <= '0;
            err              <= 1'b0;
        end else begin
            state            <= state_nxt;
            pcx_spc_grant_px <= accept ? spc_pcx_req_pq : '0;
            if (accept) begin
                atom_q <= atom_nxt;
            end
            fifo_wrreq <= wr_cycle;
            // The grant register still holds the accepted req during the grant cycle.
            if (wr_cycle) begin
                fifo_data <= {atom_q, pcx_spc_grant_px, spc_pcx_data_pa};
            end
            err <= err | underflow | (fifo_wrreq & fifo_full);
        end
    end

endmodule
